// File: rtl/lcd_frame_ctrl_if.sv
`timescale 1ns/1ps
// lcd_frame_ctrl_if
//   Groups the host character-write bus and the LCD nibble-driver handshake.
//   Host side : wr_en, wr_addr[4:0], wr_char[7:0]   (write strobe, no back-pressure)
//   Driver    : lcd_start, lcd_rs, lcd_data[7:0]    (controller -> driver)
//               lcd_busy                            (driver -> controller)
//
// Handshake: the controller pulses lcd_start for one cycle, only while
// lcd_busy is low, with lcd_rs/lcd_data valid in that cycle. The driver
// acknowledges by raising lcd_busy and signals completion by dropping it;
// the next lcd_start only follows that rise and fall.
//
// Modports: master = frame controller, slave = host + driver side.
interface lcd_frame_ctrl_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic       lcd_start;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_busy;

    modport master (
        input  wr_en, wr_addr, wr_char, lcd_busy,
        output lcd_start, lcd_rs, lcd_data
    );

    modport slave (
        output wr_en, wr_addr, wr_char, lcd_busy,
        input  lcd_start, lcd_rs, lcd_data
    );
endinterface

// File: rtl/lcd_frame_ctrl.sv
`timescale 1ns/1ps
// lcd_frame_ctrl
//   Holds a 32-character (2 x 16) display buffer and streams it to an LCD
//   nibble driver as frames: cmd 0x80, buf[0..15], cmd 0xC0, buf[16..31].
//   Frames start on a periodic refresh (only if the buffer is dirty), on a
//   forced refresh_req, or from one queued (pending) request.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (master)    : host write bus and driver handshake
//   refresh_req     : one-cycle forced-refresh request
//   active          : high while a frame is in progress
//   frame_done      : one-cycle pulse when a frame completes
//   ack_err         : sticky, set when the driver fails to raise busy in time
//   dbg_state       : current FSM state
//   dbg_dirty       : buffer-changed-since-last-frame flag
module lcd_frame_ctrl #(
    parameter int REFRESH_TICKS = 1_200_000,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lcd_frame_ctrl_if.master       bus,
    input  logic                   refresh_req,
    output logic                   active,
    output logic                   frame_done,
    output logic                   ack_err,
    output logic [2:0]             dbg_state,
    output logic                   dbg_dirty
);
    localparam int TW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic            dirty_q, dirty_d;
    logic            pending_q, pending_d;
    logic            ack_err_q, ack_err_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      char_q [32];
    logic [7:0]      char_d [32];

    logic            expire;
    logic            start_frame;
    logic            timeout;
    logic            start_pulse;
    logic            cur_rs;
    logic [7:0]      cur_data;
    logic [5:0]      idx_m1, idx_m2;

    assign expire = (timer_q == TW'(REFRESH_TICKS - 1));

    // Buffer write port: host writes land in any state.
    always_comb begin
        char_d = char_q;
        if (bus.wr_en) begin
            char_d[bus.wr_addr] = bus.wr_char;
        end
    end

    // Byte for the current transaction index, read live from the buffer so
    // writes that arrive before a byte is issued still make it into the frame.
    always_comb begin
        idx_m1   = idx_q - 6'd1;
        idx_m2   = idx_q - 6'd2;
        cur_rs   = 1'b1;
        cur_data = 8'h20;
        if (idx_q == 6'd0) begin
            cur_rs   = 1'b0;
            cur_data = 8'h80;
        end else if (idx_q == 6'd17) begin
            cur_rs   = 1'b0;
            cur_data = 8'hC0;
        end else if (idx_q < 6'd17) begin
            cur_data = char_q[idx_m1[4:0]];
        end else begin
            cur_data = char_q[idx_m2[4:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ack_cnt_d   = ack_cnt_q;
        dirty_d     = dirty_q;
        pending_d   = pending_q;
        ack_err_d   = ack_err_q;
        rs_d        = rs_q;
        data_d      = data_q;
        timer_d     = expire ? '0 : timer_q + TW'(1);
        start_pulse = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                if ((dirty_q && expire) || refresh_req || pending_q) begin
                    start_frame = 1'b1;
                    idx_d       = 6'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Also covers the driver's power-on busy period: no timeout here.
                if (!bus.lcd_busy) begin
                    start_pulse = 1'b1;
                    rs_d        = cur_rs;
                    data_d      = cur_data;
                    ack_cnt_d   = '0;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.lcd_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
                    ack_err_d = 1'b1;
                    timeout   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + AW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.lcd_busy) begin
                    if (idx_q == 6'd33) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only one extra frame is ever queued, however many requests arrive.
        if (refresh_req && (state_q != IDLE)) pending_d = 1'b1;
        if (start_frame) begin
            pending_d = 1'b0;
            dirty_d   = 1'b0;
        end
        // An aborted frame left the display stale; a same-cycle write wins
        // over the clear at frame start.
        if (timeout)    dirty_d = 1'b1;
        if (bus.wr_en)  dirty_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ack_cnt_q <= '0;
            idx_q     <= 6'd0;
            dirty_q   <= 1'b1;
            pending_q <= 1'b0;
            ack_err_q <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            for (int i = 0; i < 32; i++) char_q[i] <= 8'h20;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ack_cnt_q <= ack_cnt_d;
            idx_q     <= idx_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            ack_err_q <= ack_err_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            char_q    <= char_d;
        end
    end

    // In ISSUE the live byte is shown so it is valid alongside lcd_start;
    // elsewhere the last issued byte is held.
    assign bus.lcd_start = start_pulse;
    assign bus.lcd_rs    = (state_q == ISSUE) ? cur_rs   : rs_q;
    assign bus.lcd_data  = (state_q == ISSUE) ? cur_data : data_q;
    assign active        = (state_q != IDLE);
    assign ack_err       = ack_err_q;
    assign dbg_state     = state_q;
    assign dbg_dirty     = dirty_q;
endmodule

// File: tb/tb_lcd_frame_ctrl.sv
`timescale 1ns/1ps
// tb_lcd_frame_ctrl
//   Directed bench for lcd_frame_ctrl with a 3-cycle-busy driver model,
//   a frame scoreboard and a timer reference.
module tb_lcd_frame_ctrl;
    localparam int RT = 400;
    localparam int AT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh_req = 1'b0;
    logic       active, frame_done, ack_err;
    logic [2:0] dbg_state;
    logic       dbg_dirty;

    lcd_frame_ctrl_if bus();

    lcd_frame_ctrl #(.REFRESH_TICKS(RT), .ACK_TIMEOUT(AT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .refresh_req (refresh_req),
        .active      (active),
        .frame_done  (frame_done),
        .ack_err     (ack_err),
        .dbg_state   (dbg_state),
        .dbg_dirty   (dbg_dirty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;
    int viol     = 0;
    int t_model  = 0;
    int start_tmr = -1;
    logic       drv_mode = 1'b1;
    logic [7:0] exp_buf [32];
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Refresh timer reference: 0..RT-1, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) t_model <= 0;
        else     t_model <= (t_model == RT - 1) ? 0 : t_model + 1;
    end

    // Monitor: capture issued bytes and frame_done pulses.
    always @(negedge clk) begin
        if (bus.lcd_start) begin
            got_q.push_back({bus.lcd_rs, bus.lcd_data});
            if (bus.lcd_busy || rst) viol++;
            if (!bus.lcd_rs && bus.lcd_data == 8'h80) start_tmr = t_model;
        end
        if (frame_done) fd_cnt++;
    end

    // Driver model: busy rises the cycle after lcd_start, stays 3 cycles.
    initial begin
        bus.lcd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (drv_mode && bus.lcd_start) begin
                @(posedge clk);
                #1 bus.lcd_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 bus.lcd_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] c);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_char = c;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        exp_buf[a]  = c;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic wait_timer(input int v);
        int k;
        k = 0;
        while (t_model != v && k < 2 * RT) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) @(negedge clk);
        check(tag, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic build_frame();
        exp_q.delete();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, exp_buf[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, exp_buf[i]});
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},  32'(bus.lcd_start), 32'd0);
        check({tag, "_rs"},     32'(bus.lcd_rs),    32'd0);
        check({tag, "_data"},   32'(bus.lcd_data),  32'h00);
        check({tag, "_active"}, 32'(active),        32'd0);
        check({tag, "_fdone"},  32'(frame_done),    32'd0);
        check({tag, "_ackerr"}, 32'(ack_err),       32'd0);
        check({tag, "_state"},  32'(dbg_state),     32'd0);
        check({tag, "_dirty"},  32'(dbg_dirty),     32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic found;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 5'd0;
        bus.wr_char = 8'h00;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

        // Reset values
        tick(3);
        check_reset_outputs("reset");

        // Power-on blanking frame at the first timer expiry
        rst = 1'b0;
        got_q.delete();
        n = 0;
        while (n < RT + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.lcd_start) break;
        end
        check("first_start_cycle", 32'(n), 32'(RT));
        wait_done("f1_done", 400);
        build_frame();
        compare_frame("f1");
        tick(5);
        check("f1_fd_cnt", 32'(fd_cnt), 32'd1);
        check("f1_idle",   32'(active), 32'd0);
        check("f1_dirty",  32'(dbg_dirty), 32'd0);

        // 'A' at addr 17 shows up as the 20th transaction
        wait_timer(10);
        got_q.delete();
        fd_cnt = 0;
        write_char(5'd17, 8'h41);
        pulse_refresh();
        wait_done("f2_done", 300);
        build_frame();
        compare_frame("f2");
        check("f2_tx20_A", 32'(got_q[19]), 32'h141);
        tick(3);
        check("f2_fd_cnt", 32'(fd_cnt), 32'd1);
        check("f2_dirty",  32'(dbg_dirty), 32'd0);

        // Two requests during a frame queue exactly one more frame
        wait_timer(10);
        got_q.delete();
        fd_cnt = 0;
        pulse_refresh();
        tick(20);
        pulse_refresh();
        tick(20);
        pulse_refresh();
        wait_done("f3a_done", 300);
        wait_done("f3b_done", 300);
        wait_timer(30);
        check("f3_fd_cnt",  32'(fd_cnt), 32'd2);
        check("f3_tx_cnt",  32'(got_q.size()), 32'd68);
        check("f3_second_cmd", 32'(got_q[34]), 32'h080);
        check("f3_dirty",   32'(dbg_dirty), 32'd0);

        // Mid-frame writes: addr 0 already sent, addr 31 not yet sent
        wait_timer(5);
        got_q.delete();
        fd_cnt = 0;
        pulse_refresh();
        build_frame();
        wait_tx("f4_tx5", 5, 100);
        write_char(5'd0, 8'h55);
        write_char(5'd31, 8'h7A);
        exp_q[33] = 9'h17A;
        wait_done("f4a_done", 300);
        compare_frame("f4a");
        check("f4a_byte33",  32'(got_q[33]), 32'h17A);
        check("f4a_dirty",   32'(dbg_dirty), 32'd1);
        got_q.delete();
        wait_done("f4b_done", 2 * RT);
        build_frame();
        compare_frame("f4b");
        check("f4b_start_at_expiry", 32'(start_tmr), 32'd0);
        tick(3);
        check("f4b_dirty", 32'(dbg_dirty), 32'd0);

        // Driver never acknowledges: timeout 16 edges after the start edge
        drv_mode = 1'b0;
        got_q.delete();
        pulse_refresh();
        for (int k = 0; k < 20 && !bus.lcd_start; k++) @(negedge clk);
        found = bus.lcd_start;
        check("to_start_seen", 32'(found), 32'd1);
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("to_ackerr_before", 32'(ack_err), 32'd0);
        check("to_active_before", 32'(active),  32'd1);
        @(posedge clk);
        @(negedge clk);
        check("to_ackerr",  32'(ack_err),   32'd1);
        check("to_active",  32'(active),    32'd0);
        check("to_dirty",   32'(dbg_dirty), 32'd1);
        check("to_state",   32'(dbg_state), 32'd0);

        // Reset during transaction 10
        drv_mode = 1'b1;
        write_char(5'd3, 8'h33);
        got_q.delete();
        pulse_refresh();
        wait_tx("rst_tx10", 10, 200);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        got_q.delete();
        tick(6);
        check("midrst_no_start", 32'(got_q.size()), 32'd0);
        rst = 1'b0;
        tick(2);
        pulse_refresh();
        wait_done("f6_done", 300);
        build_frame();
        compare_frame("f6");

        check("no_start_while_busy", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
